// File: rtl/div_cascade.sv
// Pipelined unsigned restoring divider: N stages, one quotient bit per stage,
// one new operand pair accepted per enabled clock.
module div_cascade #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_valid,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dz
);

  // Stage registers; the last stage needs neither divisor nor dividend bits.
  logic         v_q [N];
  logic         v_d [N];
  logic         z_q [N];
  logic         z_d [N];
  logic [N-1:0] r_q [N];
  logic [N-1:0] r_d [N];
  logic [N-1:0] q_q [N];
  logic [N-1:0] q_d [N];
  logic [N-1:0] d_q [N-1];
  logic [N-1:0] d_d [N-1];
  logic [N-1:0] x_q [N-1];
  logic [N-1:0] x_d [N-1];

  // Per-stage view of the previous stage's register (stage 0 sees the ports).
  logic         v_in [N];
  logic         z_in [N];
  logic [N-1:0] r_in [N];
  logic [N-2:0] q_in [N];
  logic [N-1:0] d_in [N];
  logic [N-1:0] x_in [N];
  logic [N:0]   t    [N];
  logic [N-1:0] diff [N];
  logic         ge   [N];

  // NOTE: every always_comb output is fully assigned on every pass, so no latches.
  always_comb begin
    v_in[0] = in_valid;
    z_in[0] = (y == '0);
    r_in[0] = '0;
    q_in[0] = '0;
    d_in[0] = y;
    x_in[0] = x;
    for (int s = 1; s < N; s++) begin
      v_in[s] = v_q[s-1];
      z_in[s] = z_q[s-1];
      r_in[s] = r_q[s-1];
      q_in[s] = q_q[s-1][N-2:0];
      d_in[s] = d_q[s-1];
      x_in[s] = x_q[s-1];
    end

    for (int s = 0; s < N; s++) begin
      // The remainder shifted in with one dividend bit can exceed N bits,
      // so the trial compare is N+1 wide; the difference always fits in N.
      t[s]    = {r_in[s], x_in[s][N-1]};
      ge[s]   = (t[s] >= {1'b0, d_in[s]});
      diff[s] = t[s][N-1:0] - d_in[s];
      v_d[s]  = v_in[s];
      z_d[s]  = z_in[s];
      q_d[s]  = {q_in[s], ge[s]};
      r_d[s]  = ge[s] ? diff[s] : t[s][N-1:0];
    end

    for (int s = 0; s < N-1; s++) begin
      d_d[s] = d_in[s];
      x_d[s] = {x_in[s][N-2:0], 1'b0};
    end
  end

  // NOTE: the data arrays are reset too so the outputs read zero during reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < N; s++) begin
        v_q[s] <= 1'b0;
        z_q[s] <= 1'b0;
        r_q[s] <= '0;
        q_q[s] <= '0;
      end
      for (int s = 0; s < N-1; s++) begin
        d_q[s] <= '0;
        x_q[s] <= '0;
      end
    end else if (en) begin
      for (int s = 0; s < N; s++) begin
        v_q[s] <= v_d[s];
        z_q[s] <= z_d[s];
        r_q[s] <= r_d[s];
        q_q[s] <= q_d[s];
      end
      for (int s = 0; s < N-1; s++) begin
        d_q[s] <= d_d[s];
        x_q[s] <= x_d[s];
      end
    end
  end

  assign out_valid = v_q[N-1];
  assign q         = q_q[N-1];
  assign r         = r_q[N-1];
  assign dz        = z_q[N-1];

endmodule

// File: tb/tb_div_cascade.sv
// Bench for div_cascade: scoreboard of reference quotients/remainders plus
// per-scenario latency, stall and reset checks.
module tb_div_cascade;
  localparam int N = 10;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] x = '0;
  logic [N-1:0] y = '0;
  logic         out_valid;
  logic [N-1:0] q;
  logic [N-1:0] r;
  logic         dz;

  res_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  div_cascade #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
    .x(x), .y(y), .out_valid(out_valid), .q(q), .r(r), .dz(dz)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [N-1:0] a, logic [N-1:0] b);
    res_t m;
    if (b == '0) begin
      m.q = '1; m.r = a; m.dz = 1'b1;
    end else begin
      m.q = a / b; m.r = a % b; m.dz = 1'b0;
    end
    return m;
  endfunction

  // Consume a result if one is taken this cycle, record any accepted
  // operation, then advance to 1 time unit after the next rising edge.
  task automatic tick();
    res_t e;
    if (out_valid && en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got q=%0d r=%0d dz=%0b, required no result", q, r, dz);
      end else begin
        e = exp_q.pop_front();
        if ({q, r, dz} !== e) begin
          bad++;
          $display("FAIL sb_result: got q=%0d r=%0d dz=%0b, required q=%0d r=%0d dz=%0b",
                   q, r, dz, e.q, e.r, e.dz);
        end
      end
    end
    if (en && in_valid) exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, q, r, dz} !== '0) begin
      bad++;
      $display("FAIL reset_async: got v=%0b q=%0d r=%0d dz=%0b, required all 0", out_valid, q, r, dz);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_valid, q, r, dz} !== '0) begin
      bad++;
      $display("FAIL reset_held: got v=%0b q=%0d r=%0d dz=%0b, required all 0", out_valid, q, r, dz);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic exp_v;
    for (int c = 0; c <= 12; c++) begin
      en = 1'b1; in_valid = (c == 0); x = 10'd100; y = 10'd7;
      exp_v = (c == 10);
      total++;
      if (out_valid !== exp_v) begin
        bad++;
        $display("FAIL single_valid: cycle %0d got %0b, required %0b", c, out_valid, exp_v);
      end
      if (c == 10) begin
        total++;
        if (q !== 10'd14 || r !== 10'd2 || dz !== 1'b0) begin
          bad++;
          $display("FAIL single_value: got q=%0d r=%0d dz=%0b, required q=14 r=2 dz=0", q, r, dz);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] xs [3] = '{10'd1023, 10'd5, 10'd1023};
    logic [N-1:0] ys [3] = '{10'd1, 10'd9, 10'd1023};
    logic [N-1:0] eq [3] = '{10'd1023, 10'd0, 10'd1};
    logic [N-1:0] er [3] = '{10'd0, 10'd5, 10'd0};
    logic exp_v;
    for (int c = 0; c <= 14; c++) begin
      en = 1'b1;
      in_valid = (c < 3);
      if (c < 3) begin x = xs[c]; y = ys[c]; end
      exp_v = (c >= 10 && c <= 12);
      total++;
      if (out_valid !== exp_v) begin
        bad++;
        $display("FAIL b2b_valid: cycle %0d got %0b, required %0b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (q !== eq[c-10] || r !== er[c-10]) begin
          bad++;
          $display("FAIL b2b_value: cycle %0d got q=%0d r=%0d, required q=%0d r=%0d",
                   c, q, r, eq[c-10], er[c-10]);
        end
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    for (int c = 0; c <= 11; c++) begin
      en = 1'b1; in_valid = (c == 0); x = 10'd37; y = 10'd0;
      total++;
      if (out_valid !== (c == 10)) begin
        bad++;
        $display("FAIL dz_valid: cycle %0d got %0b, required %0b", c, out_valid, (c == 10));
      end
      if (c == 10) begin
        total++;
        if (q !== 10'd1023 || r !== 10'd37 || dz !== 1'b1) begin
          bad++;
          $display("FAIL dz_value: got q=%0d r=%0d dz=%0b, required q=1023 r=37 dz=1", q, r, dz);
        end
      end
      tick();
    end
  endtask

  // Stall mid-flight (cycles 4-6, with ignored in_valid), then stall again
  // while the result sits on the outputs (cycles 13-15).
  task automatic test_stall();
    logic exp_v;
    for (int c = 0; c <= 18; c++) begin
      en = !((c >= 4 && c <= 6) || (c >= 13 && c <= 15));
      in_valid = (c == 0) || (c >= 4 && c <= 6);
      x = (c == 0) ? 10'd200 : N'($urandom());
      y = (c == 0) ? 10'd3 : N'($urandom());
      exp_v = (c >= 13 && c <= 16);
      total++;
      if (out_valid !== exp_v) begin
        bad++;
        $display("FAIL stall_valid: cycle %0d got %0b, required %0b", c, out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (q !== 10'd66 || r !== 10'd2 || dz !== 1'b0) begin
          bad++;
          $display("FAIL stall_value: cycle %0d got q=%0d r=%0d dz=%0b, required q=66 r=2 dz=0",
                   c, q, r, dz);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 10; c++) begin
      en = 1'b1;
      in_valid = (c == 0) || (c >= 5 && c <= 7);
      x = (c == 0) ? 10'd100 : N'(c * 37);
      y = (c == 0) ? 10'd7 : 10'd3;
      tick();
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre: got out_valid=%0b, required 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, q, r, dz} !== '0) begin
      bad++;
      $display("FAIL rstmid_async: got v=%0b q=%0d r=%0d dz=%0b, required all 0", out_valid, q, r, dz);
    end
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_flushed: cycle %0d got out_valid=%0b, required 0", c, out_valid);
      end
      tick();
    end
    for (int c = 0; c <= 11; c++) begin
      in_valid = (c == 0); x = 10'd1023; y = 10'd1;
      total++;
      if (out_valid !== (c == 10)) begin
        bad++;
        $display("FAIL rstmid_latency: cycle %0d got %0b, required %0b", c, out_valid, (c == 10));
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 13000; c++) begin
      en = ($urandom_range(0, 99) < 85);
      in_valid = ($urandom_range(0, 99) < 80);
      x = ($urandom_range(0, 15) == 0) ? '1 : N'($urandom());
      case ($urandom_range(0, 15))
        0:       y = '0;
        1:       y = '1;
        2:       y = 10'd1;
        default: y = N'($urandom()) >> $urandom_range(0, N-1);
      endcase
      tick();
    end
    en = 1'b1;
    in_valid = 1'b0;
    repeat (N + 2) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain: %0d results outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
